inst_encoder: RTL and testbench

- Packs decoded instruction fields into the 13-bit instruction word, the same format the control unit (cu) decodes.
- Accepts fields over a valid/ready handshake and buffers them in a small FIFO.
- Drains words into instruction memory through a write port with an auto-incrementing address.
- Sits between the program loader and instruction memory during program load.

---
 rtl/inst_encoder.sv | 152 +++++++++++++++
 tb/tb_inst_encoder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_encoder.sv
// Packs decoded fields into 13-bit words, buffers them, writes to imem.
// Optional INST_COUNT_EN adds a per-session written-word counter.
module inst_encoder #(
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 4,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [3:0]        opcode,
  input  logic [3:0]        adrr,
  input  logic [2:0]        operanda,
  input  logic [2:0]        operandb,
  input  logic [2:0]        dest,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [12:0]       imem_wdata,
  output logic              done,
  output logic              wrapped
`ifdef INST_COUNT_EN
  ,
  output logic [ADDR_W:0]   inst_count
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [12:0]       mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wrap_q, wrap_d;
  logic              push, pop, m_type;
  logic [12:0]       word;

  always_comb begin
    m_type = (opcode[3:1] == 3'b111);
    if (m_type) begin
      word = {opcode, adrr, 2'b00, dest};
    end else begin
      word = {opcode, operanda, operandb, dest};
    end
  end

  always_comb begin
    in_ready = (state_q == S_RUN)
            && (cnt_q < CW'(DEPTH));
    imem_we    = (cnt_q != '0);
    imem_wdata = imem_we ? mem_q[rd_ptr_q] : 13'd0;
    imem_addr  = addr_q;
    done       = (state_q == S_DONE);
    wrapped    = wrap_q;
    push       = in_valid && in_ready;
    pop        = imem_we && imem_ready;
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wrap_d   = wrap_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          addr_d  = ADDR_W'(BASE_ADDR);
          wrap_d  = 1'b0;
        end
      end
      S_RUN: begin
        if (push && in_last) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (cnt_q == '0) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      addr_d   = addr_q + ADDR_W'(1);
      if (&addr_q) wrap_d = 1'b1;
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      addr_q   <= ADDR_W'(BASE_ADDR);
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wrap_q   <= wrap_d;
    end
  end

  // Storage needs no reset: reads are gated by the count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= word;
  end

`ifdef INST_COUNT_EN
  logic [ADDR_W:0] icnt_q, icnt_d;

  always_comb begin
    icnt_d = icnt_q;
    if (state_q == S_IDLE && start) begin
      icnt_d = '0;
    end else if (pop && !(&icnt_q)) begin
      icnt_d = icnt_q + (ADDR_W+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) icnt_q <= '0;
    else        icnt_q <= icnt_d;
  end

  assign inst_count = icnt_q;
`endif

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: two instances (ADDR_W=4 and 2).
module tb_inst_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, imem_ready, in_valid, in_last;
  logic       start_a, start_b;
  logic [3:0] opcode, adrr;
  logic [2:0] operanda, operandb, dest;

  logic        rdy_a, we_a, done_a, wrap_a;
  logic [3:0]  addr_a;
  logic [12:0] wd_a;
  logic        rdy_b, we_b, done_b, wrap_b;
  logic [1:0]  addr_b;
  logic [12:0] wd_b;
`ifdef INST_COUNT_EN
  logic [4:0]  ic_a;
  logic [2:0]  ic_b;
`endif

  inst_encoder #(.DEPTH(4), .ADDR_W(4), .BASE_ADDR(0)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a),
    .in_valid(in_valid), .in_ready(rdy_a), .in_last(in_last),
    .opcode(opcode), .adrr(adrr), .operanda(operanda),
    .operandb(operandb), .dest(dest),
    .imem_we(we_a), .imem_ready(imem_ready),
    .imem_addr(addr_a), .imem_wdata(wd_a),
    .done(done_a), .wrapped(wrap_a)
`ifdef INST_COUNT_EN
    , .inst_count(ic_a)
`endif
  );

  inst_encoder #(.DEPTH(4), .ADDR_W(2), .BASE_ADDR(0)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b),
    .in_valid(in_valid), .in_ready(rdy_b), .in_last(in_last),
    .opcode(opcode), .adrr(adrr), .operanda(operanda),
    .operandb(operandb), .dest(dest),
    .imem_we(we_b), .imem_ready(imem_ready),
    .imem_addr(addr_b), .imem_wdata(wd_b),
    .done(done_b), .wrapped(wrap_b)
`ifdef INST_COUNT_EN
    , .inst_count(ic_b)
`endif
  );

  typedef struct {
    logic [3:0]  addr;
    logic [12:0] data;
    bit          chkw;
    bit          w;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [3:0] ea;
  logic [1:0] eb;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && we_a && imem_ready) begin
      if (qa.size() == 0) chk("a_unexpected_write", 1, 0);
      else begin
        e = qa.pop_front();
        chk("a_addr", 32'(addr_a), 32'(e.addr));
        chk("a_data", 32'(wd_a), 32'(e.data));
      end
    end
    if (rst_n && we_b && imem_ready) begin
      if (qb.size() == 0) chk("b_unexpected_write", 1, 0);
      else begin
        e = qb.pop_front();
        chk("b_addr", 32'(addr_b), 32'(e.addr));
        chk("b_data", 32'(wd_b), 32'(e.data));
        if (e.chkw) chk("b_wrapped", 32'(wrap_b), 32'(e.w));
      end
    end
  end

  task automatic do_start(input bit sel);
    @(posedge clk); #1;
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
    if (sel) eb = 2'd0; else ea = 4'd0;
  endtask

  task automatic push(input bit sel, input logic [3:0] op,
                      input logic [3:0] ad, input logic [2:0] a,
                      input logic [2:0] b, input logic [2:0] d,
                      input bit last, input logic [12:0] exp,
                      input bit chkw, input bit w);
    exp_t e;
    int t = 0;
    opcode = op; adrr = ad; operanda = a;
    operandb = b; dest = d; in_last = last;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      t++;
    end while (!(sel ? rdy_b : rdy_a) && t < 100);
    chk("push_accepted", 32'(sel ? rdy_b : rdy_a), 1);
    e.data = exp; e.chkw = chkw; e.w = w;
    if (sel) begin
      e.addr = {2'b00, eb}; eb = eb + 2'd1; qb.push_back(e);
    end else begin
      e.addr = ea; ea = ea + 4'd1; qa.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done(input bit sel);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(sel ? done_b : done_a) && t < 200);
    chk("done_seen", 32'(sel ? done_b : done_a), 1);
    @(negedge clk);
    chk("done_one_cycle", 32'(sel ? done_b : done_a), 0);
    chk("queue_drained", sel ? qb.size() : qa.size(), 0);
    chk("idle_in_ready", 32'(sel ? rdy_b : rdy_a), 0);
  endtask

  initial begin
    rst_n = 1'b0; imem_ready = 1'b1;
    start_a = 1'b0; start_b = 1'b0;
    in_valid = 1'b0; in_last = 1'b0;
    opcode = '0; adrr = '0; operanda = '0;
    operandb = '0; dest = '0;
    ea = '0; eb = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(rdy_a), 0);
    chk("rst_we", 32'(we_a), 0);
    chk("rst_wdata", 32'(wd_a), 0);
    chk("rst_addr", 32'(addr_a), 0);
    chk("rst_done", 32'(done_a), 0);
    chk("rst_wrapped", 32'(wrap_a), 0);
    rst_n = 1'b1;

    // R-type single-word session
    do_start(0);
    push(0, 4'b0001, 4'hF, 3'b001, 3'b010, 3'b011, 1,
         13'h0253, 0, 0);
    @(negedge clk);
    chk("latency_we", 32'(we_a), 1);
    wait_done(0);
    chk("addr_after_r", 32'(addr_a), 1);

    // M-type pair, operand fields must be ignored
    do_start(0);
    chk("start_addr", 32'(addr_a), 0);
    push(0, 4'b1111, 4'b1100, 3'b111, 3'b111, 3'b101, 0,
         13'h1F85, 0, 0);
    push(0, 4'b1110, 4'b0100, 3'b111, 3'b111, 3'b100, 1,
         13'h1C84, 0, 0);
    wait_done(0);

    // Backpressure: 4 fill the FIFO, 5th waits
    imem_ready = 1'b0;
    do_start(0);
    push(0, 4'h1, 4'h0, 3'd1, 3'd0, 3'd0, 0, 13'h0240, 0, 0);
    push(0, 4'h2, 4'h0, 3'd2, 3'd1, 3'd1, 0, 13'h0489, 0, 0);
    push(0, 4'h3, 4'h0, 3'd3, 3'd2, 3'd2, 0, 13'h06D2, 0, 0);
    push(0, 4'h4, 4'h0, 3'd4, 3'd3, 3'd3, 0, 13'h091B, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_in_ready", 32'(rdy_a), 0);
      chk("hold_we", 32'(we_a), 1);
      chk("hold_addr", 32'(addr_a), 0);
      chk("hold_wdata", 32'(wd_a), 32'h0240);
    end
    @(posedge clk); #1;
    imem_ready = 1'b1;
    @(negedge clk);
    chk("full_pop_in_ready", 32'(rdy_a), 0);
    push(0, 4'h5, 4'h0, 3'd5, 3'd4, 3'd4, 1, 13'h0B64, 0, 0);
    wait_done(0);
`ifdef INST_COUNT_EN
    chk("inst_count_5", 32'(ic_a), 5);
`endif

    // Wrap on the 2-bit address instance
    do_start(1);
    push(1, 4'h0, 4'h0, 3'd0, 3'd0, 3'd1, 0, 13'h0001, 1, 0);
    push(1, 4'h0, 4'h0, 3'd0, 3'd0, 3'd2, 0, 13'h0002, 1, 0);
    push(1, 4'h0, 4'h0, 3'd0, 3'd0, 3'd3, 0, 13'h0003, 1, 0);
    push(1, 4'h0, 4'h0, 3'd0, 3'd0, 3'd4, 0, 13'h0004, 0, 0);
    push(1, 4'h0, 4'h0, 3'd0, 3'd0, 3'd5, 1, 13'h0005, 1, 1);
    wait_done(1);
    chk("wrapped_sticky", 32'(wrap_b), 1);
    do_start(1);
    chk("wrap_cleared", 32'(wrap_b), 0);
    chk("wrap_addr_reset", 32'(addr_b), 0);
    push(1, 4'h7, 4'h0, 3'd7, 3'd6, 3'd5, 1, 13'h0FF5, 1, 0);
    wait_done(1);

    // 3-word session for the optional counter
    do_start(0);
    push(0, 4'h8, 4'h0, 3'd1, 3'd1, 3'd1, 0, 13'h1049, 0, 0);
    push(0, 4'hE, 4'hA, 3'd0, 3'd0, 3'd6, 0, 13'h1D46, 0, 0);
    push(0, 4'hD, 4'h0, 3'd2, 3'd3, 3'd7, 1, 13'h1A9F, 0, 0);
    wait_done(0);
`ifdef INST_COUNT_EN
    chk("inst_count_3", 32'(ic_a), 3);
`endif
    do_start(0);
`ifdef INST_COUNT_EN
    chk("inst_count_clr", 32'(ic_a), 0);
`endif
    push(0, 4'h0, 4'h0, 3'd0, 3'd0, 3'd0, 1, 13'h0000, 0, 0);
    wait_done(0);

    // Reset while draining two queued words
    imem_ready = 1'b0;
    do_start(0);
    push(0, 4'h3, 4'h0, 3'd1, 3'd1, 3'd1, 0, 13'h0649, 0, 0);
    push(0, 4'h3, 4'h0, 3'd2, 3'd2, 3'd2, 1, 13'h0692, 0, 0);
    @(negedge clk);
    chk("drain_we", 32'(we_a), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_we", 32'(we_a), 0);
    chk("rst_mid_in_ready", 32'(rdy_a), 0);
    chk("rst_mid_addr", 32'(addr_a), 0);
    qa.delete();
    imem_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_done", 32'(done_a), 0);
      chk("post_rst_we", 32'(we_a), 0);
      chk("post_rst_in_ready", 32'(rdy_a), 0);
    end
    do_start(0);
    push(0, 4'h9, 4'h0, 3'd4, 3'd4, 3'd4, 1, 13'h1324, 0, 0);
    wait_done(0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
